// File: rtl/rx_sd_hyst.sv
// ---------------------------------------------------------------------------
// rx_sd_hyst -- receive-side signal detector with hysteresis
//
// Estimates |I|+|Q| for every accepted I/Q sample and runs a four-state
// detector over the magnitude stream. The flag asserts after RX_SD_ON_CNT
// consecutive samples at or above RX_SD_TH_ON. It deasserts after
// RX_SD_OFF_CNT consecutive samples below RX_SD_TH_OFF. The block also
// reports rise/fall pulses and the peak magnitude of the current or last
// burst.
//
// Handshake: a sample is consumed in any cycle where en && I_tvalid &&
// Q_tvalid. There is no backpressure, so the block is always ready. A
// sample consumed in cycle n is reflected on every output in cycle n+2.
//
// Ports
//   clk, rst        sample clock, asynchronous active-high reset
//   en              detector enable; low forces IDLE on the next edge
//   RX_SD_TH_ON     assert threshold (unsigned)
//   RX_SD_TH_OFF    deassert threshold (unsigned)
//   RX_SD_ON_CNT    consecutive hi samples needed to assert
//   RX_SD_OFF_CNT   consecutive lo samples needed to deassert
//   I_tdata/tvalid  signed I sample and its valid
//   Q_tdata/tvalid  signed Q sample and its valid
//   SD_flag         signal present (DET or HOLD)
//   SD_rise         one-cycle pulse on entry to DET from IDLE/ARMING
//   SD_fall         one-cycle pulse on entry to IDLE from DET/HOLD
//   SD_peak         max magnitude of the current/last burst
//   SD_state        0 IDLE, 1 ARMING, 2 DET, 3 HOLD (debug visibility)
// ---------------------------------------------------------------------------
module rx_sd_hyst #(
    parameter int WIDTH     = 16,
    parameter int CNT_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic [WIDTH-1:0]     RX_SD_TH_ON,
    input  logic [WIDTH-1:0]     RX_SD_TH_OFF,
    input  logic [CNT_WIDTH-1:0] RX_SD_ON_CNT,
    input  logic [CNT_WIDTH-1:0] RX_SD_OFF_CNT,
    input  logic [WIDTH-1:0]     I_tdata,
    input  logic                 I_tvalid,
    input  logic [WIDTH-1:0]     Q_tdata,
    input  logic                 Q_tvalid,
    output logic                 SD_flag,
    output logic                 SD_rise,
    output logic                 SD_fall,
    output logic [WIDTH:0]       SD_peak,
    output logic [1:0]           SD_state
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ARMING = 2'd1,
        DET    = 2'd2,
        HOLD   = 2'd3
    } state_t;

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

    // |x| as an unsigned WIDTH-bit value. The most negative input maps to
    // 2^(WIDTH-1), which still fits because the result is unsigned.
    function automatic logic [WIDTH-1:0] abs_u(input logic [WIDTH-1:0] x);
        abs_u = x[WIDTH-1] ? (~x + 1'b1) : x;
    endfunction

    // ---------------- stage 1: magnitude ----------------
    logic             accept;
    logic [WIDTH:0]   mag_calc;
    logic [WIDTH:0]   mag_q;
    logic             mag_vld;

    assign accept   = en && I_tvalid && Q_tvalid;
    assign mag_calc = {1'b0, abs_u(I_tdata)} + {1'b0, abs_u(Q_tdata)};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mag_q   <= '0;
            mag_vld <= 1'b0;
        end else begin
            // Disabling drops any sample in flight so that re-enabling
            // starts from an empty pipeline.
            mag_vld <= accept;
            if (accept) begin
                mag_q <= mag_calc;
            end
        end
    end

    // ---------------- stage 2: detector ----------------
    state_t               state;
    logic [CNT_WIDTH-1:0] cnt;
    logic [CNT_WIDTH:0]   cnt_p1;
    logic [CNT_WIDTH-1:0] cnt_sat;
    logic                 hi;
    logic                 lo;
    logic [WIDTH:0]       peak_max;

    assign hi       = mag_q >= {1'b0, RX_SD_TH_ON};
    assign lo       = mag_q <  {1'b0, RX_SD_TH_OFF};
    // One bit wider, so the run-length compare cannot wrap.
    assign cnt_p1   = {1'b0, cnt} + 1'b1;
    assign cnt_sat  = (cnt == '1) ? cnt : cnt_p1[CNT_WIDTH-1:0];
    assign peak_max = (mag_q > SD_peak) ? mag_q : SD_peak;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            SD_rise <= 1'b0;
            SD_fall <= 1'b0;
            SD_peak <= '0;
        end else begin
            SD_rise <= 1'b0;
            SD_fall <= 1'b0;
            if (!en) begin
                state <= IDLE;
                cnt   <= '0;
                if (state == DET || state == HOLD) begin
                    SD_fall <= 1'b1;
                end
            end else if (mag_vld) begin
                case (state)
                    IDLE: begin
                        if (hi) begin
                            SD_peak <= mag_q;
                            cnt     <= CNT_ONE;
                            if (RX_SD_ON_CNT <= CNT_ONE) begin
                                state   <= DET;
                                SD_rise <= 1'b1;
                            end else begin
                                state <= ARMING;
                            end
                        end
                    end
                    ARMING: begin
                        SD_peak <= peak_max;
                        if (hi) begin
                            cnt <= cnt_sat;
                            if (cnt_p1 >= {1'b0, RX_SD_ON_CNT}) begin
                                state   <= DET;
                                SD_rise <= 1'b1;
                            end
                        end else begin
                            state <= IDLE;
                            cnt   <= '0;
                        end
                    end
                    DET: begin
                        SD_peak <= peak_max;
                        if (lo) begin
                            if (RX_SD_OFF_CNT <= CNT_ONE) begin
                                state   <= IDLE;
                                cnt     <= '0;
                                SD_fall <= 1'b1;
                            end else begin
                                state <= HOLD;
                                cnt   <= CNT_ONE;
                            end
                        end else begin
                            cnt <= '0;
                        end
                    end
                    HOLD: begin
                        SD_peak <= peak_max;
                        if (lo) begin
                            if (cnt_p1 >= {1'b0, RX_SD_OFF_CNT}) begin
                                state   <= IDLE;
                                cnt     <= '0;
                                SD_fall <= 1'b1;
                            end else begin
                                cnt <= cnt_sat;
                            end
                        end else begin
                            // The signal came back before the hold expired.
                            // The detector returns to DET without a rise
                            // pulse.
                            state <= DET;
                            cnt   <= '0;
                        end
                    end
                    default: begin
                        state <= IDLE;
                        cnt   <= '0;
                    end
                endcase
            end
        end
    end

    assign SD_flag  = (state == DET) || (state == HOLD);
    assign SD_state = state;

endmodule

// File: tb/tb_rx_sd_hyst.sv
// ---------------------------------------------------------------------------
// tb_rx_sd_hyst -- directed bench for rx_sd_hyst
//
// Each driven sample that should cause a rise or fall event pushes an
// expected record onto exp_q. A record holds the event kind, the peak
// expected in that cycle, and the cycle in which the pulse must appear.
// A monitor on the falling edge pops one record per observed pulse and
// compares it. Steady-state values are checked directly by the driver.
// ---------------------------------------------------------------------------
module tb_rx_sd_hyst;

    localparam int WIDTH     = 16;
    localparam int CNT_WIDTH = 8;
    localparam int EW        = 1 + (WIDTH + 1) + 32;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 en;
    logic [WIDTH-1:0]     th_on, th_off;
    logic [CNT_WIDTH-1:0] on_cnt, off_cnt;
    logic [WIDTH-1:0]     i_data, q_data;
    logic                 i_vld, q_vld;
    logic                 sd_flag, sd_rise, sd_fall;
    logic [WIDTH:0]       sd_peak;
    logic [1:0]           sd_state;

    int unsigned cyc = 0;
    int vectors = 0;
    int miscompares = 0;

    // {is_rise, peak, cycle}
    logic [EW-1:0] exp_q[$];

    rx_sd_hyst #(.WIDTH(WIDTH), .CNT_WIDTH(CNT_WIDTH)) dut (
        .clk(clk), .rst(rst), .en(en),
        .RX_SD_TH_ON(th_on), .RX_SD_TH_OFF(th_off),
        .RX_SD_ON_CNT(on_cnt), .RX_SD_OFF_CNT(off_cnt),
        .I_tdata(i_data), .I_tvalid(i_vld),
        .Q_tdata(q_data), .Q_tvalid(q_vld),
        .SD_flag(sd_flag), .SD_rise(sd_rise), .SD_fall(sd_fall),
        .SD_peak(sd_peak), .SD_state(sd_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every rise/fall pulse consumes one expected record.
    always @(negedge clk) begin
        if (!rst) begin
            if (sd_rise && sd_fall) begin
                vectors++;
                miscompares++;
                $display("FAIL rise_fall_overlap: got both pulses expected one (cycle %0d)", cyc);
            end else if (sd_rise || sd_fall) begin
                vectors++;
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL unexpected_event: got rise=%0b fall=%0b expected none (cycle %0d)",
                             sd_rise, sd_fall, cyc);
                end else begin
                    logic [EW-1:0] e;
                    e = exp_q.pop_front();
                    if (sd_rise !== e[EW-1] || sd_peak !== e[EW-2:32] || cyc !== e[31:0]) begin
                        miscompares++;
                        $display("FAIL event: got rise=%0b peak=%0d cycle=%0d expected rise=%0b peak=%0d cycle=%0d",
                                 sd_rise, sd_peak, cyc, e[EW-1], e[EW-2:32], e[31:0]);
                    end
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic push_ev(input bit is_rise, input int peak, input int dly);
        logic [EW-1:0] e;
        e = {is_rise, (WIDTH + 1)'(peak), 32'(cyc + dly)};
        exp_q.push_back(e);
    endtask

    // ev: 0 none, 1 rise, 2 fall expected two cycles after this sample
    task automatic send(input int i, input int q, input int ev = 0, input int peak = 0);
        if (ev != 0) push_ev(ev == 1, peak, 2);
        i_data = WIDTH'(i);
        q_data = WIDTH'(q);
        i_vld  = 1'b1;
        q_vld  = 1'b1;
        @(posedge clk); #1;
        i_vld  = 1'b0;
        q_vld  = 1'b0;
    endtask

    // A gap cycle with only one of the two valids set; it must be ignored.
    task automatic gap(input bit i_only);
        i_data = WIDTH'(5000);
        q_data = WIDTH'(5000);
        i_vld  = i_only;
        q_vld  = !i_only;
        @(posedge clk); #1;
        i_vld  = 1'b0;
        q_vld  = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk); #1;
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst = 1'b1; en = 1'b1;
        th_on = 16'd1000; th_off = 16'd500; on_cnt = 8'd4; off_cnt = 8'd3;
        i_data = '0; q_data = '0; i_vld = 1'b0; q_vld = 1'b0;
        idle(3);
        check("reset_state", 32'(sd_state), 0);
        check("reset_flag", 32'(sd_flag), 0);
        check("reset_peak", 32'(sd_peak), 0);
        check("reset_pulses", 32'({sd_rise, sd_fall}), 0);
        rst = 1'b0;
        idle(2);

        // T1: four hi samples of magnitude 1100 assert the flag
        for (int k = 0; k < 4; k++) send(600, 500, (k == 3) ? 1 : 0, 1100);
        idle(3);
        check("t1_state", 32'(sd_state), 2);
        check("t1_flag", 32'(sd_flag), 1);
        check("t1_peak", 32'(sd_peak), 1100);

        // T2: HOLD, back to DET without a rise, then HOLD and release
        send(60, 40); send(60, 40);
        idle(2);
        check("t2_hold", 32'(sd_state), 3);
        send(400, 300);
        idle(2);
        check("t2_back_det", 32'(sd_state), 2);
        send(60, 40); send(60, 40); send(60, 40, 2, 1100);
        idle(3);
        check("t2_state", 32'(sd_state), 0);
        check("t2_flag", 32'(sd_flag), 0);
        check("t2_peak_held", 32'(sd_peak), 1100);

        // T3: a mid-level sample breaks the arming run
        send(600, 500); send(600, 500); send(600, 500);
        send(500, 400);
        idle(3);
        check("t3_arm_reset", 32'(sd_state), 0);
        check("t3_arm_peak", 32'(sd_peak), 1100);
        send(600, 500); send(600, 500); send(600, 500);
        send(-32768, -32768, 1, 65536);
        idle(3);
        check("t3_peak_max", 32'(sd_peak), 65536);
        send(10, 10); send(10, 10); send(10, 10, 2, 65536);
        idle(3);

        // T4: half-valid gaps inside the runs only delay the events
        send(600, 500); gap(1'b1); send(600, 500); gap(1'b0); gap(1'b1);
        send(600, 500); send(600, 500, 1, 1100);
        idle(3);
        check("t4_det", 32'(sd_state), 2);
        send(10, 10); gap(1'b1); send(10, 10); gap(1'b0); send(10, 10, 2, 1100);
        idle(3);
        check("t4_idle", 32'(sd_state), 0);

        // T5: ON_CNT=0 and OFF_CNT=1 react to single samples
        on_cnt = 8'd0; off_cnt = 8'd1;
        send(1000, 200, 1, 1200);
        idle(2);
        check("t5_single_hi", 32'(sd_state), 2);
        send(10, 10, 2, 1200);
        idle(2);
        check("t5_single_lo", 32'(sd_state), 0);
        // ON_CNT=255 with a long run: exactly one rise, on the 255th sample
        on_cnt = 8'd255; off_cnt = 8'd3;
        for (int k = 0; k < 300; k++) send(600, 500, (k == 254) ? 1 : 0, 1100);
        idle(3);
        check("t5_long_det", 32'(sd_state), 2);

        // T6: dropping en while in DET gives a fall on the next edge
        push_ev(1'b0, 1100, 1);
        en = 1'b0;
        @(posedge clk); #1;
        check("t6_en_state", 32'(sd_state), 0);
        send(600, 500);  // ignored while disabled
        idle(2);
        check("t6_en_ignored", 32'(sd_state), 0);
        check("t6_en_peak", 32'(sd_peak), 1100);
        en = 1'b1;
        on_cnt = 8'd4;
        idle(1);

        // Asynchronous reset in ARMING clears outputs without a clock edge
        send(600, 500); send(600, 500);
        idle(2);
        check("t6_arming", 32'(sd_state), 1);
        #1 rst = 1'b1;
        #1;
        check("t6_rst_state", 32'(sd_state), 0);
        check("t6_rst_outputs", 32'({sd_flag, sd_rise, sd_fall}), 0);
        check("t6_rst_peak", 32'(sd_peak), 0);
        #1 rst = 1'b0;
        idle(4);

        check("events_outstanding", 32'(exp_q.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
